// File: rtl/esdi_pkg.sv
// rtl/esdi_pkg.sv - shared state encoding and bit positions for the ESDI command arbiter
package esdi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        WAIT_IDLE,
        WAIT_CC,
        RETURN
    } state_t;

    localparam int WORD_W      = 17;
    localparam int RSP_W       = 19;
    localparam int CC_TO_BIT   = 18;
    localparam int XFER_TO_BIT = 17;
    localparam int PERR_BIT    = 16;
    localparam int QUERY_BIT   = 16;

endpackage

// File: rtl/esdi_rr_arbiter.sv
// rtl/esdi_rr_arbiter.sv - round-robin requester picker
// ESDI_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority instead.
module esdi_rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               hit,
    output logic [IW-1:0]      idx
);

`ifdef ESDI_ARB_FIXED_PRIORITY_EN
    logic unused_ptr_inputs;
    assign unused_ptr_inputs = ^{clk, reset, advance};

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;

    // Scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        logic [IW:0]   cand;
        logic [IW-1:0] cidx;
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        cidx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            cidx = cand[IW-1:0];
            if (req[cidx]) begin
                hit = 1'b1;
                idx = cidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
    end
`endif

endmodule

// File: rtl/esdi_cmd_arbiter.sv
// rtl/esdi_cmd_arbiter.sv - shares the ESDI serial command channel between requesters
// ESDI_ARB_FIXED_PRIORITY_EN (in esdi_rr_arbiter) switches grant order to fixed priority.
module esdi_cmd_arbiter
    import esdi_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int CC_TIMEOUT = 50_000_000
) (
    input  logic                   csr_aclk,
    input  logic                   csr_areset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [17*NUM_REQ-1:0]  req_data,
    input  logic [4*NUM_REQ-1:0]   req_drive,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [18:0]            rsp_data,
    output logic                   ser_valid,
    input  logic                   ser_ready,
    output logic [16:0]            ser_data,
    input  logic                   ser_idle,
    input  logic                   ser_rsp_valid,
    input  logic [17:0]            ser_rsp_data,
    input  logic                   esdi_command_complete,
    output logic [3:0]             esdi_drive_select
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CC_TIMEOUT + 1);

    state_t        state, state_next;
    logic [IW-1:0] owner;
    logic [CW-1:0] cnt;
    logic [1:0]    cc_sync;
    logic          settle;
    logic          hit, grant, accept;
    logic [IW-1:0] idx;

    esdi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_pick (
        .clk     (csr_aclk),
        .reset   (csr_areset),
        .req     (req_valid),
        .advance (grant),
        .hit     (hit),
        .idx     (idx)
    );

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE:      if (hit) begin
                           grant      = 1'b1;
                           state_next = ISSUE;
                       end
            ISSUE:     if (ser_valid && ser_ready) begin
                           accept     = 1'b1;
                           state_next = ser_data[QUERY_BIT] ? WAIT_RSP : WAIT_IDLE;
                       end
            WAIT_RSP:  if (ser_rsp_valid) state_next = RETURN;
            WAIT_IDLE: if (!settle && ser_idle) state_next = WAIT_CC;
            WAIT_CC:   if (!cc_sync[1] || cnt == CW'(CC_TIMEOUT - 1)) state_next = RETURN;
            RETURN:    if (rsp_ready[owner]) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge csr_aclk) begin
        if (csr_areset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // settle marks the one-cycle pause after grant (drive select) and after accept (ser_idle)
    always_ff @(posedge csr_aclk) begin
        if (csr_areset) begin
            req_ready         <= '0;
            rsp_valid         <= '0;
            rsp_data          <= '0;
            ser_valid         <= 1'b0;
            ser_data          <= '0;
            esdi_drive_select <= '0;
            owner             <= '0;
            cnt               <= '0;
            cc_sync           <= 2'b11;
            settle            <= 1'b0;
        end else begin
            cc_sync   <= {cc_sync[0], esdi_command_complete};
            req_ready <= '0;
            if (grant) begin
                owner             <= idx;
                ser_data          <= req_data[int'(idx)*WORD_W +: WORD_W];
                esdi_drive_select <= req_drive[int'(idx)*4 +: 4];
                req_ready         <= NUM_REQ'(1) << idx;
                settle            <= 1'b1;
            end
            case (state)
                ISSUE: begin
                    if (settle) begin
                        settle    <= 1'b0;
                        ser_valid <= 1'b1;
                    end else if (accept) begin
                        ser_valid <= 1'b0;
                        settle    <= 1'b1;
                    end
                end
                WAIT_RSP:
                    if (ser_rsp_valid) rsp_data <= {1'b0, ser_rsp_data};
                WAIT_IDLE: begin
                    if (settle)
                        settle <= 1'b0;
                    else if (ser_idle)
                        cnt <= '0;
                end
                WAIT_CC: begin
                    if (!cc_sync[1]) begin
                        rsp_data <= '0;
                    end else if (cnt == CW'(CC_TIMEOUT - 1)) begin
                        rsp_data            <= '0;
                        rsp_data[CC_TO_BIT] <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
            if (state != RETURN && state_next == RETURN)
                rsp_valid <= NUM_REQ'(1) << owner;
            else if (state == RETURN && rsp_ready[owner])
                rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_esdi_cmd_arbiter.sv
// tb/tb_esdi_cmd_arbiter.sv - directed self-checking bench for esdi_cmd_arbiter
module tb_esdi_cmd_arbiter;

    localparam int N = 2;

    logic          csr_aclk = 1'b0;
    logic          csr_areset;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [17*N-1:0] req_data;
    logic [4*N-1:0]  req_drive;
    logic [18:0]   rsp_data;
    logic          ser_valid, ser_ready, ser_idle, ser_rsp_valid;
    logic [16:0]   ser_data;
    logic [17:0]   ser_rsp_data;
    logic          esdi_command_complete;
    logic [3:0]    esdi_drive_select;

    int total = 0;
    int bad   = 0;

    esdi_cmd_arbiter #(.NUM_REQ(N), .CC_TIMEOUT(1000)) dut (
        .csr_aclk              (csr_aclk),
        .csr_areset            (csr_areset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_data              (req_data),
        .req_drive             (req_drive),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_data              (rsp_data),
        .ser_valid             (ser_valid),
        .ser_ready             (ser_ready),
        .ser_data              (ser_data),
        .ser_idle              (ser_idle),
        .ser_rsp_valid         (ser_rsp_valid),
        .ser_rsp_data          (ser_rsp_data),
        .esdi_command_complete (esdi_command_complete),
        .esdi_drive_select     (esdi_drive_select)
    );

    always #5 csr_aclk = ~csr_aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge csr_aclk);
        #1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == '0 && n < 50);
        g = req_ready;
    endtask

    // Called in the grant cycle; returns in the cycle the result appears.
    task automatic serve_query(input logic [16:0] w, input logic [17:0] resp);
        tick();
        check_eq("issue_valid", ser_valid, 1);
        check_eq("issue_data", ser_data, w);
        tick();
        ser_rsp_data  = resp;
        ser_rsp_valid = 1'b1;
        tick();
        ser_rsp_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_ser_valid"}, ser_valid, 0);
        check_eq({tag, "_ser_data"}, ser_data, 0);
        check_eq({tag, "_drive"}, esdi_drive_select, 0);
    endtask

    logic [N-1:0] g, exp_g;
    int errs;

    initial begin
        csr_areset = 1'b1;
        req_valid = '0; req_data = '0; req_drive = '0; rsp_ready = '0;
        ser_ready = 1'b1; ser_idle = 1'b1; ser_rsp_valid = 1'b0; ser_rsp_data = '0;
        esdi_command_complete = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        csr_areset = 1'b0;
        tick();

        // query from requester 1
        req_data  = {17'h1_0055, 17'h0};
        req_drive = {4'h2, 4'h0};
        req_valid = 2'b10;
        tick();
        check_eq("q_grant", req_ready, 2'b10);
        check_eq("q_drive", esdi_drive_select, 4'h2);
        check_eq("q_settle", ser_valid, 0);
        req_valid = '0;
        serve_query(17'h1_0055, 18'h0_ABCD);
        check_eq("q_rsp_valid", rsp_valid, 2'b10);
        check_eq("q_rsp_data", rsp_data, 19'h0ABCD);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = '0;
        check_eq("q_rsp_drop", rsp_valid, 0);

        // command from requester 0 completed by cc
        req_data  = {17'h0, 17'h0_1234};
        req_drive = {4'h0, 4'h5};
        ser_idle  = 1'b0;
        req_valid = 2'b01;
        tick();
        check_eq("c_grant", req_ready, 2'b01);
        check_eq("c_drive", esdi_drive_select, 4'h5);
        req_valid = '0;
        tick();
        check_eq("c_issue", ser_data, 17'h0_1234);
        tick();
        repeat (5) tick();
        ser_idle = 1'b1;
        tick();
        repeat (100) tick();
        check_eq("c_wait", rsp_valid, 0);
        esdi_command_complete = 1'b0;
        tick();
        tick();
        check_eq("c_sync_lat", rsp_valid, 0);
        tick();
        check_eq("c_rsp_valid", rsp_valid, 2'b01);
        check_eq("c_rsp_data", rsp_data, 0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        esdi_command_complete = 1'b1;

        // command from requester 1 with cc never arriving
        req_data  = {17'h0_0001, 17'h0};
        req_drive = {4'h3, 4'h0};
        req_valid = 2'b10;
        tick();
`ifdef ESDI_ARB_FIXED_PRIORITY_EN
        exp_g = 2'b10;
`else
        exp_g = 2'b10;
`endif
        check_eq("t_grant", req_ready, exp_g);
        check_eq("t_drive", esdi_drive_select, 4'h3);
        req_valid = '0;
        tick();
        check_eq("t_issue", ser_valid, 1);
        tick();
        tick();
        tick();
        repeat (999) tick();
        check_eq("t_early", rsp_valid, 0);
        tick();
        check_eq("t_rsp_valid", rsp_valid, 2'b10);
        check_eq("t_rsp_data", rsp_data, 19'h40000);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = '0;

        // both requesters continuously valid
        req_data  = {17'h1_0011, 17'h1_0022};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_grant(g);
`ifdef ESDI_ARB_FIXED_PRIORITY_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
            check_eq($sformatf("fair_grant%0d", i), g, exp_g);
            serve_query(g[1] ? 17'h1_0011 : 17'h1_0022, 18'(i + 16));
            check_eq($sformatf("fair_owner%0d", i), rsp_valid, exp_g);
            check_eq($sformatf("fair_data%0d", i), rsp_data, 19'(i + 16));
            rsp_ready = 2'b11;
            tick();
            rsp_ready = '0;
            if (i == 5) req_valid = '0;
        end

        // backpressure on requester 0, transfer timeout flag in result
        req_data  = {17'h1_0011, 17'h1_0077};
        req_valid = 2'b01;
        wait_grant(g);
        check_eq("bp_grant", g, 2'b01);
        req_valid = '0;
        serve_query(17'h1_0077, 18'h2_BEEF);
        check_eq("bp_rsp_data", rsp_data, 19'h2BEEF);
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        errs = 0;
        repeat (50) begin
            tick();
            if (rsp_data !== 19'h2BEEF || rsp_valid !== 2'b01 || req_ready !== 2'b00) errs++;
        end
        check_eq("bp_hold", errs, 0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        check_eq("bp_release", rsp_valid, 0);
        check_eq("bp_idle_gap", req_ready, 0);
        tick();
`ifdef ESDI_ARB_FIXED_PRIORITY_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        check_eq("bp_next_grant", req_ready, exp_g);
        req_valid = '0;

        // reset while waiting for the query result
        tick();
        tick();
        csr_areset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        csr_areset = 1'b0;
        tick();
        ser_rsp_data  = 18'h0_1111;
        ser_rsp_valid = 1'b1;
        tick();
        ser_rsp_valid = 1'b0;
        repeat (3) tick();
        check_eq("midrst_no_rsp", rsp_valid, 0);
        check_eq("midrst_no_issue", ser_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/esdi_cmd_arbiter.md
Name: esdi_cmd_arbiter

Overview:
Shares the single ESDI serial command channel (17-bit command/config-status serializer) between NUM_REQ requesters, e.g. the CPU register path and the hardware read/write sequencer. It grants one requester at a time, drives that requester's drive select, and forwards the command word to the serializer. It then holds the channel until the transfer finishes: a query returns its response word, and a command waits for ESDI Command Complete or a timeout. The result is routed back to the originating requester only.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CC_TIMEOUT, 50_000_000, max cycles waiting for Command Complete after a command (500 ms @ 100 MHz)

Ports:
csr_aclk  in  1  clock
csr_areset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_data  in  17*NUM_REQ  slice i: [16]=query, [15:0]=command word
req_drive  in  4*NUM_REQ  slice i: drive select for that command
rsp_valid  out  NUM_REQ  per-requester result valid
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  19  shared result: [18]=cc timeout, [17]=transfer timeout, [16]=parity error, [15:0]=data
ser_valid  out  1  word to serializer valid
ser_ready  in  1  serializer accepts word
ser_data  out  17  word to serializer
ser_idle  in  1  serializer in idle state
ser_rsp_valid  in  1  single-cycle query result pulse
ser_rsp_data  in  18  [17]=timeout, [16]=parity error, [15:0]=data
esdi_command_complete  in  1  raw ESDI Command Complete, active low
esdi_drive_select  out  4  drive select to the ESDI cable

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, ser_valid=0, ser_data=0, esdi_drive_select=0, state=IDLE, rr pointer=0, cc synchronizer=2'b11.
- esdi_command_complete passes through a 2-flop synchronizer. "cc asserted" means the synchronized value is 0.
- State IDLE:
  - Round-robin search among asserted req_valid, starting at the rr pointer.
  - On a hit i: latch owner=i, the word and the drive. Assert req_ready[i] for exactly that cycle (the request is consumed). Load esdi_drive_select=req_drive[i] the same cycle.
  - Set rr pointer=(i+1) mod NUM_REQ (wraps). Go to ISSUE.
- State ISSUE:
  - ser_valid=1 with the latched word; wait one cycle first so drive select settles before issue.
  - On ser_valid&&ser_ready: drop ser_valid. If query -> WAIT_RSP, else -> WAIT_IDLE.
- State WAIT_RSP: on ser_rsp_valid, rsp_data={1'b0, ser_rsp_data} -> RETURN.
- State WAIT_IDLE:
  - When ser_idle=1, clear the cycle counter -> WAIT_CC.
  - The serializer must be idle at least one cycle after accepting before this is checked, so ser_idle is ignored in the first cycle after acceptance.
- State WAIT_CC:
  - On cc asserted: rsp_data=19'h0 -> RETURN.
  - Else if counter==CC_TIMEOUT-1: rsp_data={1'b1, 18'h0} -> RETURN.
- State RETURN:
  - rsp_valid[owner]=1, held with rsp_data stable until rsp_ready[owner] -> IDLE.
  - rsp_ready on other bits is ignored.
- Timing rules:
  - Grant latency: req_valid to req_ready is 1 cycle from IDLE.
  - A new grant is not made in the same cycle as a RETURN handshake, so IDLE lasts at least 1 cycle.
- esdi_drive_select retains its last value in IDLE; it is only changed at grant.
- Simultaneous events:
  - A requester holding a RETURN result may re-request; it is not granted until its response is accepted.
  - All req_valid asserted: service order is 0,1,...,NUM_REQ-1,0 (fairness).
- Serializer transfer timeout on a query propagates as rsp_data[17]=1.
- Reset mid-operation: returns to IDLE at once and any in-flight result is discarded. The serializer must share csr_areset.

Optional Feature:
ESDI_ARB_FIXED_PRIORITY_EN:
- Defined: fixed priority, lowest index wins; the rr pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package esdi_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT_RSP, WAIT_IDLE, WAIT_CC, RETURN);
  - result bit positions (CC_TO_BIT=18, XFER_TO_BIT=17, PERR_BIT=16);
  - the word field positions (QUERY_BIT=16).
- One sub-module, esdi_rr_arbiter: combinational-plus-pointer round-robin picker, NUM_REQ wide, with the fixed-priority macro handled inside it.

Test Plan:
- Query from req 1, drive 4'h2:
  - req_ready[1] is asserted 1 cycle after req_valid; esdi_drive_select=2.
  - ser_data=17'h1_0055 is issued; the model returns 18'h0_ABCD.
  - Result: rsp_valid[1] with rsp_data=19'h0ABCD; rsp_valid[0] stays 0.
- Command 17'h0_1234 from req 0; the model pulls cc low 100 cycles after ser_idle -> rsp_valid[0] with rsp_data=0, no earlier than cc+2 cycles (synchronizer).
- Command with cc held high and CC_TIMEOUT=1000 -> rsp_data=19'h40000 exactly 1000 cycles after WAIT_CC entry.
- Both requesters continuously valid, 6 transactions -> grants 0,1,0,1,0,1. With ESDI_ARB_FIXED_PRIORITY_EN: all 6 grants go to 0.
- Backpressure: rsp_ready[0] held low for 50 cycles -> rsp_data stable, no new grant to either requester until acceptance.
- csr_areset asserted during WAIT_RSP -> next cycle all outputs at reset values. A later ser_rsp_valid pulse produces no rsp_valid.
